// File: rtl/expu_accumulator.sv
// expu_accumulator: streaming bfloat16-style group accumulator.
//
// Sums the magnitudes of a group of floating-point beats (closed by last_i)
// with a widened internal mantissa, then presents the rounded sum and the
// saturating beat count behind a valid/ready handshake.
//
// Optional feature macro: EXPU_ACC_RNE_EN
//   defined   -> output is rounded to nearest, ties to even
//   undefined -> output is truncated
//
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   clear_i             synchronous abort of the current group / pending result
//   valid_i, ready_o    input beat handshake (ready_o high only while accumulating)
//   float_i, last_i     {sign, exp, mant} beat and group terminator
//   valid_o, ready_i    result handshake
//   sum_o, count_o      registered group sum (sign always 0) and beat count
module expu_accumulator #(
    parameter int unsigned EXPONENT_BITS     = 8,
    parameter int unsigned MANTISSA_BITS     = 7,
    parameter int unsigned ACC_MANTISSA_BITS = 16,
    parameter int unsigned COUNT_WIDTH       = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 clear_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    input  logic [EXPONENT_BITS+MANTISSA_BITS:0] float_i,
    input  logic                                 last_i,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic [EXPONENT_BITS+MANTISSA_BITS:0] sum_o,
    output logic [COUNT_WIDTH-1:0]               count_o
);

    localparam int unsigned ExpW  = EXPONENT_BITS;
    localparam int unsigned ManW  = MANTISSA_BITS;
    localparam int unsigned AccW  = ACC_MANTISSA_BITS;
    localparam int unsigned CntW  = COUNT_WIDTH;
    localparam int unsigned DropW = AccW - ManW;
    localparam int unsigned SumW  = ExpW + ManW + 1;

    typedef enum logic [0:0] {StAcc, StOut} state_e;

    state_e            st_q, st_d;
    logic [ExpW-1:0]   acc_exp_q, acc_exp_d;
    logic [AccW-1:0]   acc_man_q, acc_man_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [SumW-1:0]   sum_q, sum_d;

    // Input fields; the sign bit is deliberately ignored.
    logic [ExpW-1:0]   in_exp;
    logic [ManW-1:0]   in_man;
    logic              in_zero, in_inf, acc_zero, acc_inf;

    assign in_exp   = float_i[SumW-2:ManW];
    assign in_man   = float_i[ManW-1:0];
    assign in_zero  = (in_exp == '0);
    assign in_inf   = (in_exp == '1);
    assign acc_zero = (acc_exp_q == '0);
    assign acc_inf  = (acc_exp_q == '1);

    // Alignment of the two significands (hidden bit included).
    logic [AccW:0]     acc_full, in_full, big_full, small_full, small_shift;
    logic [ExpW-1:0]   big_exp, exp_diff;
    logic [AccW+1:0]   sum_wide;
    logic              acc_ge;

    assign acc_full    = {1'b1, acc_man_q};
    assign in_full     = {1'b1, in_man, {DropW{1'b0}}};
    assign acc_ge      = (acc_exp_q >= in_exp);
    assign big_full    = acc_ge ? acc_full : in_full;
    assign small_full  = acc_ge ? in_full : acc_full;
    assign big_exp     = acc_ge ? acc_exp_q : in_exp;
    assign exp_diff    = acc_ge ? (acc_exp_q - in_exp) : (in_exp - acc_exp_q);
    // Beyond AccW positions the smaller operand vanishes entirely.
    assign small_shift = (32'(exp_diff) > AccW) ? '0 : (small_full >> exp_diff);
    assign sum_wide    = {1'b0, big_full} + {1'b0, small_shift};

    // Accumulator value after adding the current beat.
    logic [ExpW-1:0]   add_exp;
    logic [AccW-1:0]   add_man;

    always_comb begin
        add_exp = acc_exp_q;
        add_man = acc_man_q;
        if (acc_inf || in_inf) begin
            add_exp = '1;
            add_man = '0;
        end else if (in_zero) begin
            add_exp = acc_exp_q;
            add_man = acc_man_q;
        end else if (acc_zero) begin
            add_exp = in_exp;
            add_man = {in_man, {DropW{1'b0}}};
        end else begin
            if (sum_wide[AccW+1]) begin
                add_exp = big_exp + ExpW'(1);
                add_man = sum_wide[AccW:1];
            end else begin
                add_exp = big_exp;
                add_man = sum_wide[AccW-1:0];
            end
            if (add_exp == '1) begin
                add_man = '0;
            end
        end
    end

    // Reduction of the accumulator to the output format.
    logic [ExpW-1:0]   conv_exp;
    logic [ManW-1:0]   conv_man;
    logic [SumW-1:0]   conv_sum;

`ifdef EXPU_ACC_RNE_EN
    localparam logic [DropW-1:0] LowMask = {DropW{1'b1}} >> 1;
    logic              guard_bit, sticky_bit, round_up;
    logic [ManW:0]     rnd_man;

    always_comb begin
        guard_bit  = add_man[DropW-1];
        sticky_bit = |(add_man[DropW-1:0] & LowMask);
        round_up   = guard_bit & (sticky_bit | add_man[DropW]);
        rnd_man    = {1'b0, add_man[AccW-1:DropW]} + {{ManW{1'b0}}, round_up};
        // A mantissa carry leaves the fraction at zero; at the top exponent that is inf.
        conv_exp   = rnd_man[ManW] ? (add_exp + ExpW'(1)) : add_exp;
        conv_man   = rnd_man[ManW-1:0];
    end
`else
    always_comb begin
        conv_exp = add_exp;
        conv_man = add_man[AccW-1:DropW];
    end
`endif

    assign conv_sum = (add_exp == '0) ? '0 : {1'b0, conv_exp, conv_man};

    // Next-state and handshake outputs.
    always_comb begin
        st_d      = st_q;
        acc_exp_d = acc_exp_q;
        acc_man_d = acc_man_q;
        count_d   = count_q;
        sum_d     = sum_q;
        ready_o   = (st_q == StAcc);
        valid_o   = (st_q == StOut);
        if (clear_i) begin
            st_d      = StAcc;
            acc_exp_d = '0;
            acc_man_d = '0;
            count_d   = '0;
            sum_d     = '0;
        end else begin
            unique case (st_q)
                StAcc: begin
                    if (valid_i) begin
                        acc_exp_d = add_exp;
                        acc_man_d = add_man;
                        count_d   = (count_q == '1) ? count_q : (count_q + CntW'(1));
                        if (last_i) begin
                            st_d  = StOut;
                            sum_d = conv_sum;
                        end
                    end
                end
                StOut: begin
                    if (ready_i) begin
                        st_d      = StAcc;
                        acc_exp_d = '0;
                        acc_man_d = '0;
                        count_d   = '0;
                        sum_d     = '0;
                    end
                end
                default: st_d = StAcc;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            st_q      <= StAcc;
            acc_exp_q <= '0;
            acc_man_q <= '0;
            count_q   <= '0;
            sum_q     <= '0;
        end else begin
            st_q      <= st_d;
            acc_exp_q <= acc_exp_d;
            acc_man_q <= acc_man_d;
            count_q   <= count_d;
            sum_q     <= sum_d;
        end
    end

    assign sum_o   = sum_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_expu_accumulator.sv
module tb_expu_accumulator;

    localparam int CW = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          valid = 1'b0;
    logic          ready_o;
    logic [15:0]   fin = '0;
    logic          last = 1'b0;
    logic          valid_o;
    logic          rdy = 1'b0;
    logic [15:0]   sum_o;
    logic [CW-1:0] count_o;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    expu_accumulator #(
        .EXPONENT_BITS    (8),
        .MANTISSA_BITS    (7),
        .ACC_MANTISSA_BITS(16),
        .COUNT_WIDTH      (CW)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clear_i(clear),
        .valid_i(valid),
        .ready_o(ready_o),
        .float_i(fin),
        .last_i (last),
        .valid_o(valid_o),
        .ready_i(rdy),
        .sum_o  (sum_o),
        .count_o(count_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: significand m as an integer with 17 bits (hidden 1 at bit 16),
    // value = m * 2^(e-127-16). m == 0 means zero; e == 255 means inf.
    function automatic void mdl_add(inout int e, inout longint m, input logic [15:0] x);
        int xe;
        int d;
        longint xs;
        xe = int'(x[14:7]);
        if (e == 255 || xe == 0) return;
        if (xe == 255) begin
            e = 255;
            m = 0;
            return;
        end
        xs = longint'({1'b1, x[6:0]}) << 9;
        if (m == 0) begin
            e = xe;
            m = xs;
            return;
        end
        if (e >= xe) begin
            d = e - xe;
            m = m + ((d > 16) ? 64'd0 : (xs >> d));
        end else begin
            d = xe - e;
            m = xs + ((d > 16) ? 64'd0 : (m >> d));
            e = xe;
        end
        if (m >= (longint'(1) << 17)) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e == 255) m = 0;
    endfunction

    function automatic logic [15:0] mdl_conv(input int e, input longint m);
        longint kept;
        int ee;
        ee = e;
        if (ee == 255) return 16'h7F80;
        if (m == 0) return 16'h0000;
        kept = m >> 9;
`ifdef EXPU_ACC_RNE_EN
        begin
            longint rem;
            rem = m & 511;
            if (rem > 256 || (rem == 256 && kept[0])) kept = kept + 1;
        end
`endif
        if (kept == 256) begin
            kept = 128;
            ee = ee + 1;
        end
        if (ee >= 255) return 16'h7F80;
        return {1'b0, 8'(ee), 7'(kept - 128)};
    endfunction

    // Model state
    bit          m_out = 1'b0;
    int          m_e = 0;
    longint      m_m = 0;
    int          m_cnt = 0;
    logic [15:0] m_sum = '0;

    always @(posedge clk) begin : model
        int e;
        longint m;
        int c;
        bit o;
        logic [15:0] s;
        e = m_e; m = m_m; c = m_cnt; o = m_out; s = m_sum;
        if (!rst_n || clear) begin
            e = 0; m = 0; c = 0; o = 1'b0; s = '0;
        end else if (!o) begin
            if (valid) begin
                mdl_add(e, m, fin);
                if (c < CMAX) c = c + 1;
                if (last) begin
                    o = 1'b1;
                    s = mdl_conv(e, m);
                end
            end
        end else if (rdy) begin
            e = 0; m = 0; c = 0; o = 1'b0; s = '0;
        end
        m_e <= e; m_m <= m; m_cnt <= c; m_out <= o; m_sum <= s;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_ready", 32'(ready_o), 32'(!m_out));
            chk("cmp_valid", 32'(valid_o), 32'(m_out));
            if (m_out) begin
                chk("cmp_sum", 32'(sum_o), 32'(m_sum));
                chk("cmp_count", 32'(count_o), 32'(m_cnt));
            end
        end
    end

    task automatic cyc(input bit v, input logic [15:0] x, input bit l, input bit r, input bit c);
        valid = v; fin = x; last = l; rdy = r; clear = c;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [15:0] rnd_f();
        int k;
        logic [7:0] e;
        k = $urandom_range(15);
        if (k == 0) e = 8'h00;
        else if (k == 1) e = 8'hFF;
        else if (k <= 3) e = 8'($urandom_range(254, 245));
        else e = 8'($urandom_range(140, 110));
        return {1'($urandom_range(1)), e, 7'($urandom)};
    endfunction

    initial begin
        int e;
        longint m;
        logic [15:0] exp_rne;

`ifdef EXPU_ACC_RNE_EN
        exp_rne = 16'h3F82;
`else
        exp_rne = 16'h3F81;
`endif

        // Model pinned against hand-computed values
        e = 0; m = 0;
        for (int i = 0; i < 4; i++) mdl_add(e, m, 16'h3F80);
        chk("mdl_four", 32'(mdl_conv(e, m)), 32'h4080);
        e = 0; m = 0;
        mdl_add(e, m, 16'h3F81);
        mdl_add(e, m, 16'h3B80);
        chk("mdl_round", 32'(mdl_conv(e, m)), 32'(exp_rne));

        rst_n = 1'b0;
        cyc(0, 16'h0, 0, 0, 0);
        chk_en = 1'b1;
        cyc(0, 16'h0, 0, 0, 0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_sum", 32'(sum_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        rst_n = 1'b1;

        // 4 x 1.0
        for (int i = 0; i < 3; i++) cyc(1, 16'h3F80, 0, 0, 0);
        cyc(1, 16'h3F80, 1, 0, 0);
        chk("four_valid", 32'(valid_o), 32'd1);
        chk("four_sum", 32'(sum_o), 32'h4080);
        chk("four_count", 32'(count_o), 32'd4);
        cyc(0, 16'h0, 0, 1, 0);
        chk("four_release", 32'(ready_o), 32'd1);

        // Rounding of a half-ulp addend
        cyc(1, 16'h3F81, 0, 0, 0);
        cyc(1, 16'h3B80, 1, 0, 0);
        chk("round_sum", 32'(sum_o), 32'(exp_rne));
        cyc(0, 16'h0, 0, 1, 0);

        // Overflow to inf, and inf stays sticky
        cyc(1, 16'h7F7F, 0, 0, 0);
        cyc(1, 16'h7F7F, 1, 0, 0);
        chk("ovf_sum", 32'(sum_o), 32'h7F80);
        cyc(0, 16'h0, 0, 1, 0);
        cyc(1, 16'h7F7F, 0, 0, 0);
        cyc(1, 16'h7F7F, 0, 0, 0);
        cyc(1, 16'h3F80, 1, 0, 0);
        chk("inf_sticky", 32'(sum_o), 32'h7F80);
        chk("inf_count", 32'(count_o), 32'd3);
        cyc(0, 16'h0, 0, 1, 0);

        // Zero beat counted; sign ignored
        cyc(1, 16'h0000, 0, 0, 0);
        cyc(1, 16'h3F80, 1, 0, 0);
        chk("zero_sum", 32'(sum_o), 32'h3F80);
        chk("zero_count", 32'(count_o), 32'd2);
        cyc(0, 16'h0, 0, 1, 0);
        cyc(1, 16'hBF80, 1, 0, 0);
        chk("sign_sum", 32'(sum_o), 32'h3F80);
        cyc(0, 16'h0, 0, 1, 0);

        // Backpressure with a beat offered meanwhile
        cyc(1, 16'h4000, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 16'h3F80, 1, 0, 0);
            chk("bp_valid", 32'(valid_o), 32'd1);
            chk("bp_ready", 32'(ready_o), 32'd0);
            chk("bp_sum", 32'(sum_o), 32'h4000);
            chk("bp_count", 32'(count_o), 32'd1);
        end
        cyc(0, 16'h0, 0, 1, 0);
        cyc(1, 16'h3F80, 1, 0, 0);
        chk("bp_next_count", 32'(count_o), 32'd1);
        cyc(0, 16'h0, 0, 1, 0);

        // Clear drops the group and the beat offered with it
        cyc(1, 16'h4000, 0, 0, 0);
        cyc(1, 16'h4000, 0, 0, 0);
        cyc(1, 16'h4000, 0, 0, 1);
        cyc(1, 16'h3F80, 1, 0, 0);
        chk("clr_sum", 32'(sum_o), 32'h3F80);
        chk("clr_count", 32'(count_o), 32'd1);
        cyc(0, 16'h0, 0, 1, 0);

        // Reset during OUT
        cyc(1, 16'h4000, 1, 0, 0);
        chk("pre_rst_valid", 32'(valid_o), 32'd1);
        rst_n = 1'b0;
        cyc(0, 16'h0, 0, 0, 0);
        chk("rst_out_valid", 32'(valid_o), 32'd0);
        chk("rst_out_count", 32'(count_o), 32'd0);
        rst_n = 1'b1;

        // Count saturation (20 beats into a 4-bit counter)
        for (int i = 0; i < 19; i++) cyc(1, 16'h3F80, 0, 1, 0);
        cyc(1, 16'h3F80, 1, 0, 0);
        chk("sat_sum", 32'(sum_o), 32'h41A0);
        chk("sat_count", 32'(count_o), 32'd15);
        cyc(0, 16'h0, 0, 1, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(99) != 0);
            cyc(($urandom_range(3) != 0), rnd_f(), ($urandom_range(3) == 0),
                1'($urandom_range(1)), ($urandom_range(39) == 0));
        end
        rst_n = 1'b1;
        cyc(0, 16'h0, 0, 1, 0);
        cyc(0, 16'h0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
